// File: rtl/reel_sequencer.sv
// Slot-machine reel sequencer: reels track rand_num and freeze one per tick, then classify matches.
// Optional REEL_STOP_BTN_EN adds a stop_p input that freezes the current reel early.
module reel_sequencer #(
   parameter int unsigned NUM_REELS   = 3,
   parameter int unsigned DIGIT_W     = 4,
   parameter int unsigned TICK_CYCLES = 100_000_000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic                          start_p,
   input  logic [DIGIT_W-1:0]            rand_num,
   input  logic [$clog2(NUM_REELS)-1:0]  rd_sel,
`ifdef REEL_STOP_BTN_EN
   input  logic                          stop_p,
`endif
   output logic [NUM_REELS*DIGIT_W-1:0]  reels,
   output logic [DIGIT_W-1:0]            rd_data,
   output logic                          busy,
   output logic                          match_all,
   output logic                          match_pair,
   output logic                          score_reset,
   output logic                          turn_p
);

   localparam int unsigned CNT_W = $clog2(TICK_CYCLES);
   localparam int unsigned SEL_W = $clog2(NUM_REELS);

   typedef enum logic [1:0] {IDLE, SPIN, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [SEL_W-1:0]   idx;
   logic [DIGIT_W-1:0] reel_q [NUM_REELS];

   logic               tick;
   logic               freeze;
   logic               all_eq;
   logic               any_eq;
   logic [DIGIT_W-1:0] rd_next;

   assign tick = (cnt == CNT_W'(TICK_CYCLES - 1));
`ifdef REEL_STOP_BTN_EN
   assign freeze = tick | stop_p;
`else
   assign freeze = tick;
`endif

   for (genvar g = 0; g < NUM_REELS; g++) begin : g_pack
      assign reels[g*DIGIT_W +: DIGIT_W] = reel_q[g];
   end

   // Match classification and read-back mux over the frozen reel registers
   always_comb begin
      all_eq  = 1'b1;
      any_eq  = 1'b0;
      rd_next = '0;
      for (int i = 1; i < NUM_REELS; i++) begin
         if (reel_q[i] != reel_q[0]) all_eq = 1'b0;
      end
      for (int i = 0; i < NUM_REELS; i++) begin
         for (int j = i + 1; j < NUM_REELS; j++) begin
            if (reel_q[i] == reel_q[j]) any_eq = 1'b1;
         end
      end
      for (int i = 0; i < NUM_REELS; i++) begin
         if (rd_sel == SEL_W'(i)) rd_next = reel_q[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         idx         <= '0;
         busy        <= 1'b0;
         match_all   <= 1'b0;
         match_pair  <= 1'b0;
         score_reset <= 1'b0;
         turn_p      <= 1'b0;
         rd_data     <= '0;
         for (int i = 0; i < NUM_REELS; i++) reel_q[i] <= '0;
      end else begin
         score_reset <= 1'b0;
         turn_p      <= 1'b0;
         rd_data     <= rd_next;
         case (state)
            IDLE: begin
               if (start_p && enable) begin
                  state       <= SPIN;
                  busy        <= 1'b1;
                  cnt         <= '0;
                  idx         <= '0;
                  score_reset <= 1'b1;
                  match_all   <= 1'b0;
                  match_pair  <= 1'b0;
                  for (int i = 0; i < NUM_REELS; i++) reel_q[i] <= '0;
               end
            end
            SPIN: begin
               // enable low freezes everything, so a pause resumes from the same count
               if (enable) begin
                  reel_q[idx] <= rand_num;
                  if (freeze) begin
                     cnt <= '0;
                     if (idx == SEL_W'(NUM_REELS - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                     end else begin
                        idx <= idx + SEL_W'(1);
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               match_all  <= all_eq;
               match_pair <= any_eq & ~all_eq;
               turn_p     <= 1'b1;
               idx        <= '0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reel_sequencer.sv
// Directed bench for reel_sequencer (NUM_REELS=3, DIGIT_W=4, TICK_CYCLES=4).
// Define REEL_STOP_BTN_EN for both files to exercise the stop button.
module tb_reel_sequencer;

   localparam int unsigned NR = 3;
   localparam int unsigned DW = 4;
   localparam int unsigned TC = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             enable;
   logic             start_p;
   logic [DW-1:0]    rand_num;
   logic [1:0]       rd_sel;
`ifdef REEL_STOP_BTN_EN
   logic             stop_p;
`endif
   logic [NR*DW-1:0] reels;
   logic [DW-1:0]    rd_data;
   logic             busy;
   logic             match_all;
   logic             match_pair;
   logic             score_reset;
   logic             turn_p;

   int n_vec = 0;
   int n_err = 0;

   reel_sequencer #(.NUM_REELS(NR), .DIGIT_W(DW), .TICK_CYCLES(TC)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .start_p     (start_p),
      .rand_num    (rand_num),
      .rd_sel      (rd_sel),
`ifdef REEL_STOP_BTN_EN
      .stop_p      (stop_p),
`endif
      .reels       (reels),
      .rd_data     (rd_data),
      .busy        (busy),
      .match_all   (match_all),
      .match_pair  (match_pair),
      .score_reset (score_reset),
      .turn_p      (turn_p)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs observed 1 ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; start_p = 1'b0; rand_num = '0; rd_sel = '0;
`ifdef REEL_STOP_BTN_EN
      stop_p = 1'b0;
`endif
      step(); step();
      n_vec++;
      if ({reels, rd_data, busy, match_all, match_pair, score_reset, turn_p} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got reels=%h rd=%h busy=%b all=%b pair=%b sr=%b turn=%b, expected all 0",
                  reels, rd_data, busy, match_all, match_pair, score_reset, turn_p);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_match_all();
      int turn_at;
      turn_at = -1;
      rand_num = 4'd5; enable = 1'b1; start_p = 1'b1;
      step();
      start_p = 1'b0;
      n_vec++;
      if (score_reset !== 1'b1) begin n_err++; $display("FAIL t1_score_reset: got %b expected 1", score_reset); end
      n_vec++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL t1_busy: got %b expected 1", busy); end
      for (int c = 1; c <= 40; c++) begin
         if (turn_p === 1'b1) begin turn_at = c; break; end
         step();
      end
      n_vec++;
      if (turn_at != 14) begin n_err++; $display("FAIL t1_turn_latency: got %0d expected 14", turn_at); end
      n_vec++;
      if (reels !== 12'h555) begin n_err++; $display("FAIL t1_reels: got %h expected 555", reels); end
      n_vec++;
      if ({match_all, match_pair} !== 2'b10) begin
         n_err++; $display("FAIL t1_match: got all=%b pair=%b expected all=1 pair=0", match_all, match_pair);
      end
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL t1_busy_done: got %b expected 0", busy); end
      step();
   endtask

   task automatic test_match_pair();
      int turn_at;
      turn_at = -1;
      enable = 1'b1; start_p = 1'b1; rd_sel = 2'd2;
      step();
      start_p = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (c == 6) begin
            n_vec++;
            if (reels !== 12'h0B1) begin n_err++; $display("FAIL t2_mid_reels: got %h expected 0b1", reels); end
         end
         if (turn_p === 1'b1) begin turn_at = c; break; end
         if (c == 4 || c == 12) rand_num = 4'd1;
         else if (c == 8)        rand_num = 4'd2;
         else                    rand_num = DW'(c + 6);
         step();
      end
      n_vec++;
      if (turn_at != 14) begin n_err++; $display("FAIL t2_turn_latency: got %0d expected 14", turn_at); end
      n_vec++;
      if (reels !== 12'h121) begin n_err++; $display("FAIL t2_reels: got %h expected 121", reels); end
      n_vec++;
      if ({match_all, match_pair} !== 2'b01) begin
         n_err++; $display("FAIL t2_match: got all=%b pair=%b expected all=0 pair=1", match_all, match_pair);
      end
      n_vec++;
      if (rd_data !== 4'd1) begin n_err++; $display("FAIL t2_rd_sel2: got %h expected 1", rd_data); end
      rd_sel = 2'd1;
      step();
      n_vec++;
      if (rd_data !== 4'd2) begin n_err++; $display("FAIL t2_rd_sel1: got %h expected 2", rd_data); end
      rd_sel = 2'd3;
      step();
      n_vec++;
      if (rd_data !== 4'd0) begin n_err++; $display("FAIL t2_rd_sel3: got %h expected 0", rd_data); end
      rd_sel = 2'd0;
      step();
   endtask

   task automatic test_pause();
      int turn_at;
      turn_at = -1;
      enable = 1'b1; start_p = 1'b1; rand_num = 4'd6;
      step();
      start_p = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         if (c == 10) begin
            n_vec++;
            if (reels !== 12'h066) begin n_err++; $display("FAIL t3_pause_reels: got %h expected 066", reels); end
            n_vec++;
            if (busy !== 1'b1) begin n_err++; $display("FAIL t3_pause_busy: got %b expected 1", busy); end
         end
         if (turn_p === 1'b1) begin turn_at = c; break; end
         enable   = !(c >= 6 && c <= 15);
         rand_num = enable ? 4'd6 : 4'd9;
         step();
      end
      enable = 1'b1;
      n_vec++;
      if (turn_at != 24) begin n_err++; $display("FAIL t3_turn_latency: got %0d expected 24", turn_at); end
      n_vec++;
      if (reels !== 12'h666) begin n_err++; $display("FAIL t3_reels: got %h expected 666", reels); end
      step();
   endtask

   task automatic test_start_ignored();
      int n_turn;
      int n_sr;
      int turn_at;
      n_turn = 0; n_sr = 0; turn_at = -1;
      enable = 1'b1; start_p = 1'b1; rand_num = 4'd5;
      step();
      for (int c = 1; c <= 30; c++) begin
         if (score_reset === 1'b1) n_sr++;
         if (turn_p === 1'b1) begin n_turn++; if (turn_at < 0) turn_at = c; end
         start_p = (c == 3 || c == 7 || c == 13);
         step();
      end
      start_p = 1'b0;
      n_vec++;
      if (n_turn != 1) begin n_err++; $display("FAIL t4_turn_count: got %0d expected 1", n_turn); end
      n_vec++;
      if (turn_at != 14) begin n_err++; $display("FAIL t4_turn_latency: got %0d expected 14", turn_at); end
      n_vec++;
      if (n_sr != 1) begin n_err++; $display("FAIL t4_score_reset_count: got %0d expected 1", n_sr); end
      enable = 1'b0; start_p = 1'b1;
      step();
      start_p = 1'b0;
      n_vec++;
      if ({score_reset, busy} !== 2'b00) begin
         n_err++; $display("FAIL t4_disabled_start: got sr=%b busy=%b expected 0 0", score_reset, busy);
      end
      step();
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL t4_disabled_no_latch: got busy=%b expected 0", busy); end
      enable = 1'b1;
   endtask

   task automatic test_reset_mid_spin();
      int turn_at;
      turn_at = -1;
      enable = 1'b1; start_p = 1'b1; rand_num = 4'd4; rd_sel = 2'd0;
      step();
      start_p = 1'b0;
      for (int c = 1; c <= 9; c++) step();
      n_vec++;
      if ({reels, busy} !== {12'h444, 1'b1}) begin
         n_err++; $display("FAIL t5_pre_reset: got reels=%h busy=%b expected 444 1", reels, busy);
      end
      #1 rst = 1'b1;
      #1;
      n_vec++;
      if ({reels, rd_data, busy, match_all, match_pair, score_reset, turn_p} !== '0) begin
         n_err++;
         $display("FAIL t5_async_reset: got reels=%h rd=%h busy=%b all=%b pair=%b sr=%b turn=%b, expected all 0",
                  reels, rd_data, busy, match_all, match_pair, score_reset, turn_p);
      end
      #1 rst = 1'b0;
      step();
      rand_num = 4'd3; start_p = 1'b1;
      step();
      start_p = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (turn_p === 1'b1) begin turn_at = c; break; end
         step();
      end
      n_vec++;
      if (turn_at != 14) begin n_err++; $display("FAIL t5_turn_latency: got %0d expected 14", turn_at); end
      n_vec++;
      if ({reels, match_all, match_pair} !== {12'h333, 2'b10}) begin
         n_err++; $display("FAIL t5_after_reset: got reels=%h all=%b pair=%b expected 333 1 0", reels, match_all, match_pair);
      end
      step();
   endtask

`ifdef REEL_STOP_BTN_EN
   task automatic test_stop_btn();
      int turn_at;
      turn_at = -1;
      enable = 1'b1; start_p = 1'b1; rand_num = 4'd7;
      step();
      start_p = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (turn_p === 1'b1) begin turn_at = c; break; end
         stop_p = (c == 2 || c == 4 || c == 6);
         step();
      end
      stop_p = 1'b0;
      n_vec++;
      if (turn_at != 8) begin n_err++; $display("FAIL t6_stop_latency: got %0d expected 8", turn_at); end
      n_vec++;
      if (reels !== 12'h777) begin n_err++; $display("FAIL t6_stop_reels: got %h expected 777", reels); end
      step();
      turn_at = -1;
      start_p = 1'b1;
      step();
      start_p = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (turn_p === 1'b1) begin turn_at = c; break; end
         stop_p = (c == 4);
         step();
      end
      stop_p = 1'b0;
      n_vec++;
      if (turn_at != 14) begin n_err++; $display("FAIL t6_stop_on_tick: got %0d expected 14", turn_at); end
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_match_all();
      test_match_pair();
      test_pause();
      test_start_ignored();
      test_reset_mid_spin();
`ifdef REEL_STOP_BTN_EN
      test_stop_btn();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
